// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with a configurable word length, parity mode and number of stop bits.
// A completed word is held in rx_data with valid/ack handshaking; a frame that completes while the held word is unconsumed is dropped.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 baud_tick,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_meta_q, rx_s_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, frame_err_q, parity_err_q, overrun_q;
  logic                 done;
  logic                 sample;
  logic                 frame_par;
  logic                 perr_new;
  logic                 ferr_new;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
    end
  end

  assign sample = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sr_d    = sr_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    if (baud_tick) begin
      cnt_d = sample ? '0 : cnt_q + CW'(1);
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!rx_s_q) state_d = S_START;
        end
        S_START: begin
          // Re-check at mid start bit to reject glitches.
          if (cnt_q == CNT_HALF) begin
            cnt_d   = '0;
            bit_d   = '0;
            ferr_d  = 1'b0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (sample) begin
            sr_d  = {rx_s_q, sr_q[DATA_BITS-1:1]};
            bit_d = bit_q + 4'd1;
            if (bit_q == BIT_LAST) begin
              stop_d  = 1'b0;
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (sample) begin
            par_d   = rx_s_q;
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (sample) begin
            ferr_d = ferr_q | ~rx_s_q;
            stop_d = 1'b1;
            if (stop_q == STOP_LAST) begin
              done    = 1'b1;
              state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          cnt_d = '0;
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign frame_par = (^sr_q) ^ par_q;
  assign perr_new  = (PARITY == 1) ? ~frame_par : (PARITY == 2) ? frame_par : 1'b0;
  assign ferr_new  = ferr_q | ~rx_s_q;

  // An ack on the completion edge frees the holding register for the new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (rx_ack) rx_valid_q <= 1'b0;
      if (done) begin
        if (!rx_valid_q || rx_ack) begin
          rx_data_q    <= sr_q;
          frame_err_q  <= ferr_new;
          parity_err_q <= perr_new;
          rx_valid_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: a default-parameter instance and an even-parity instance share clock and baud tick.
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_q = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic rx_ack0 = 1'b0, rx_ack1 = 1'b0;
  logic [7:0] data0, data1;
  logic valid0, ferr0, perr0, ovr0, busy0;
  logic valid1, ferr1, perr1, ovr1, busy1;

  int total = 0;
  int bad = 0;
  int vrise0 = 0;
  int ovr_cnt0 = 0;
  int rises_before;
  int ovr_before;
  time t_start = 0;
  time t_rise = 0;
  time offset;
  event frame_go;

  uart_rx_param dut0 (
    .clk(clk), .reset(reset), .rx(rx0), .baud_tick(tick_q), .rx_ack(rx_ack0),
    .rx_data(data0), .rx_valid(valid0), .frame_err(ferr0), .parity_err(perr0),
    .overrun(ovr0), .busy(busy0)
  );

  uart_rx_param #(.PARITY(2)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .baud_tick(tick_q), .rx_ack(rx_ack1),
    .rx_data(data1), .rx_valid(valid1), .frame_err(ferr1), .parity_err(perr1),
    .overrun(ovr1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Baud tick on every other clock edge, so the divider gating is exercised.
  always @(negedge clk) tick_q <= ~tick_q;

  always @(posedge valid0) begin
    vrise0++;
    t_rise = $time;
  end

  always @(negedge clk) if (ovr0) ovr_cnt0++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic bitwait();
    repeat (32) @(negedge clk);
  endtask

  // Starts at a fixed baud-tick phase so completion timing repeats frame to frame.
  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input bit par_en, input logic par, input logic stop, input int nstop);
    @(negedge clk);
    while (!tick_q) @(negedge clk);
    t_start = $time;
    ->frame_go;
    set_rx(sel, 1'b0);
    bitwait();
    for (int i = 0; i < nbits; i++) begin
      set_rx(sel, data[i]);
      bitwait();
    end
    if (par_en) begin
      set_rx(sel, par);
      bitwait();
    end
    for (int i = 0; i < nstop; i++) begin
      set_rx(sel, stop);
      bitwait();
    end
  endtask

  task automatic ack(input int sel);
    @(negedge clk);
    if (sel == 0) rx_ack0 = 1'b1;
    else rx_ack1 = 1'b1;
    @(negedge clk);
    rx_ack0 = 1'b0;
    rx_ack1 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid0), 0);
    check("rst_data", 32'(data0), 0);
    check("rst_ferr", 32'(ferr0), 0);
    check("rst_perr", 32'(perr0), 0);
    check("rst_ovr", 32'(ovr0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_busy1", 32'(busy1), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1);
    check("a5_valid", 32'(valid0), 1);
    check("a5_data", 32'(data0), 32'h0A5);
    check("a5_ferr", 32'(ferr0), 0);
    check("a5_perr", 32'(perr0), 0);
    repeat (50) @(negedge clk);
    check("a5_hold_valid", 32'(valid0), 1);
    check("a5_hold_data", 32'(data0), 32'h0A5);
    ack(0);
    check("a5_ack_valid", 32'(valid0), 0);
    check("a5_idle_busy", 32'(busy0), 0);

    send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1'b1, 1);
    check("par_bad_valid", 32'(valid1), 1);
    check("par_bad_data", 32'(data1), 32'h03);
    check("par_bad_perr", 32'(perr1), 1);
    check("par_bad_ferr", 32'(ferr1), 0);
    ack(1);
    send_frame(1, 9'h003, 8, 1'b1, 1'b0, 1'b1, 1);
    check("par_ok_valid", 32'(valid1), 1);
    check("par_ok_data", 32'(data1), 32'h03);
    check("par_ok_perr", 32'(perr1), 0);
    ack(1);

    rises_before = vrise0;
    @(negedge clk);
    rx0 = 1'b0;
    repeat (6) @(negedge clk);
    check("glitch_busy_hi", 32'(busy0), 1);
    rx0 = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy_lo", 32'(busy0), 0);
    check("glitch_valid", 32'(valid0), 0);
    check("glitch_rises", 32'(vrise0), 32'(rises_before));

    rises_before = vrise0;
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b0, 1);
    check("brk_valid", 32'(valid0), 1);
    check("brk_data", 32'(data0), 32'h55);
    check("brk_ferr", 32'(ferr0), 1);
    check("brk_wait_busy", 32'(busy0), 1);
    ack(0);
    repeat (40) bitwait();
    check("brk_long_valid", 32'(valid0), 0);
    check("brk_long_busy", 32'(busy0), 1);
    check("brk_one_word", 32'(vrise0), 32'(rises_before + 1));
    rx0 = 1'b1;
    repeat (20) @(negedge clk);
    check("brk_release_busy", 32'(busy0), 0);

    ovr_before = ovr_cnt0;
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1);
    check("ovr_data", 32'(data0), 32'h11);
    check("ovr_valid", 32'(valid0), 1);
    check("ovr_pulse", 32'(ovr_cnt0), 32'(ovr_before + 1));
    ack(0);

    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1);
    offset = t_rise - t_start;
    check("ovr2_first_data", 32'(data0), 32'h11);
    ovr_before = ovr_cnt0;
    fork
      send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1);
      begin
        @(frame_go);
        #(offset - 5);
        rx_ack0 = 1'b1;
        #10;
        rx_ack0 = 1'b0;
      end
    join
    check("same_edge_data", 32'(data0), 32'h22);
    check("same_edge_valid", 32'(valid0), 1);
    check("same_edge_no_ovr", 32'(ovr_cnt0), 32'(ovr_before));
    ack(0);

    rises_before = vrise0;
    @(negedge clk);
    rx0 = 1'b0;
    bitwait();
    rx0 = 1'b0; bitwait();
    rx0 = 1'b1; bitwait();
    rx0 = 1'b1; bitwait();
    rx0 = 1'b1; bitwait();
    rx0 = 1'b1;
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(valid0), 0);
    check("midrst_data", 32'(data0), 0);
    check("midrst_ferr", 32'(ferr0), 0);
    check("midrst_perr", 32'(perr0), 0);
    check("midrst_ovr", 32'(ovr0), 0);
    check("midrst_busy", 32'(busy0), 0);
    reset = 1'b0;
    repeat (64) @(negedge clk);
    check("midrst_no_word", 32'(vrise0), 32'(rises_before));
    send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 1'b1, 1);
    check("after_rst_valid", 32'(valid0), 1);
    check("after_rst_data", 32'(data0), 32'h7E);
    check("after_rst_ferr", 32'(ferr0), 0);
    ack(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
